// File: rtl/serial_add_sub_if.sv
// Operand/result handshake bundle for the digit-serial add/subtract unit.
// The master drives operands and accepts results; the slave is the arithmetic unit.
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/serial_add_sub.sv
// Digit-serial add/subtract: DIGIT bits per clock, LSB first, carry held in a flop.
// Subtraction is a + ~b + ~cin, so cout=1 means "no borrow".
//
// state | meaning
// IDLE  | ready for an operand pair
// RUN   | one DIGIT-bit slice per cycle
// DONE  | result held until consumer accepts
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_sub_if.slave  bus
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_last;
  logic [DIGIT:0]   w_slice;
  logic             w_c_msb;
  logic [WIDTH-1:0] w_sum_nxt;

  assign w_slice = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
  // Carry into the slice's top bit recovered from its sum bit and operand bits.
  assign w_c_msb = w_slice[DIGIT-1] ^ r_a[DIGIT-1] ^ r_b[DIGIT-1];
  assign w_last  = (r_cnt == CW'(STEPS - 1));

  generate
    if (DIGIT == WIDTH) begin : g_sum_full
      assign w_sum_nxt = w_slice[DIGIT-1:0];
    end else begin : g_sum_shift
      assign w_sum_nxt = {w_slice[DIGIT-1:0], r_sum[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub ^ bus.cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_sum   <= w_sum_nxt;
          r_carry <= w_slice[DIGIT];
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_cout <= w_slice[DIGIT];
            r_ovf  <= w_c_msb ^ w_slice[DIGIT];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: directed 8-bit/1-digit cases plus random 16-bit/4-digit ops
// checked against an integer-arithmetic reference model.
module tb_serial_add_sub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_add_sub_if #(.WIDTH(8))  bus8();
  serial_add_sub_if #(.WIDTH(16)) bus16();

  serial_add_sub #(.WIDTH(8),  .DIGIT(1)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_add_sub #(.WIDTH(16), .DIGIT(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic int sx(input int w, input int x);
    return (x >= (1 << (w - 1))) ? x - (1 << w) : x;
  endfunction

  function automatic void model(input int w, input int a, input int b, input int cin, input int sub,
                                output int s, output int co, output int ov);
    int r, sr;
    if (sub == 0) begin
      r  = a + b + cin;
      co = (r >= (1 << w)) ? 1 : 0;
      sr = sx(w, a) + sx(w, b) + cin;
    end else begin
      r  = a - b - cin;
      co = (r >= 0) ? 1 : 0;
      sr = sx(w, a) - sx(w, b) - cin;
    end
    s  = r & ((1 << w) - 1);
    ov = (sr > (1 << (w - 1)) - 1 || sr < -(1 << (w - 1))) ? 1 : 0;
  endfunction

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                     input int hold, input string tag);
    int s, co, ov, lat;
    model(8, int'(a), int'(b), int'(cin), int'(sub), s, co, ov);
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.sub = sub; bus8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    // keep in_valid high with different operands: must be ignored while busy
    bus8.a = ~a; bus8.b = 8'($urandom); bus8.cin = ~cin; bus8.sub = ~sub;
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (lat == 2) check_val({tag, "/in_ready_run"}, 32'(bus8.in_ready), 0);
    end while (!bus8.out_valid && lat < 40);
    bus8.in_valid = 1'b0;
    check_val({tag, "/latency"}, lat, 8);
    check_val({tag, "/sum"},  32'(bus8.sum),  s);
    check_val({tag, "/cout"}, 32'(bus8.cout), co);
    check_val({tag, "/ovf"},  32'(bus8.ovf),  ov);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_val({tag, "/hold_valid"}, 32'(bus8.out_valid), 1);
      check_val({tag, "/hold_ready"}, 32'(bus8.in_ready), 0);
      check_val({tag, "/hold_sum"},   32'({bus8.sum, bus8.cout, bus8.ovf}), 32'((s << 2) | (co << 1) | ov));
    end
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1 bus8.out_ready = 1'b0;
    @(negedge clk);
    check_val({tag, "/valid_drop"}, 32'(bus8.out_valid), 0);
    check_val({tag, "/idle_ready"}, 32'(bus8.in_ready), 1);
  endtask

  task automatic op16_random();
    logic [15:0] a, b;
    logic cin, sub, acc;
    int s, co, ov, lat, cyc;
    a = 16'($urandom); b = 16'($urandom);
    cin = 1'($urandom); sub = 1'($urandom);
    model(16, int'(a), int'(b), int'(cin), int'(sub), s, co, ov);
    @(negedge clk);
    bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.sub = sub; bus16.in_valid = 1'b1;
    @(posedge clk);
    #1 bus16.in_valid = 1'b0;
    bus16.a = 16'($urandom); bus16.b = 16'($urandom);
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!bus16.out_valid && lat < 40);
    check_val("t6/latency", lat, 4);
    check_val("t6/sum",  32'(bus16.sum),  s);
    check_val("t6/cout", 32'(bus16.cout), co);
    check_val("t6/ovf",  32'(bus16.ovf),  ov);
    cyc = 0;
    do begin
      bus16.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      acc = bus16.out_ready;
      #1 bus16.out_ready = 1'b0;
      @(negedge clk);
      if (!acc) check_val("t6/hold_sum", 32'(bus16.sum), s);
      cyc++;
    end while (!acc && cyc < 50);
    check_val("t6/release", 32'(acc), 1);
    check_val("t6/valid_drop", 32'(bus16.out_valid), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus8.in_valid = 0;  bus8.a = 0;  bus8.b = 0;  bus8.cin = 0;  bus8.sub = 0;  bus8.out_ready = 0;
    bus16.in_valid = 0; bus16.a = 0; bus16.b = 0; bus16.cin = 0; bus16.sub = 0; bus16.out_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst/in_ready",  32'(bus8.in_ready), 1);
    check_val("rst/out_valid", 32'(bus8.out_valid), 0);
    check_val("rst/sum",       32'(bus8.sum), 0);
    check_val("rst/cout_ovf",  32'({bus8.cout, bus8.ovf}), 0);
    check_val("rst16/state",   32'({bus16.in_ready, bus16.out_valid}), 2);
    rst_n = 1'b1;

    op8(8'h0F, 8'h01, 1'b0, 1'b0, 0, "t1");
    op8(8'h7F, 8'h01, 1'b0, 1'b0, 0, "t2a");
    op8(8'hFF, 8'h00, 1'b1, 1'b0, 0, "t2b");
    op8(8'h05, 8'h07, 1'b0, 1'b1, 0, "t3a");
    op8(8'h80, 8'h01, 1'b0, 1'b1, 0, "t3b");
    op8(8'h00, 8'h01, 1'b1, 1'b1, 0, "sub_borrow");
    op8(8'h80, 8'h80, 1'b0, 1'b0, 0, "neg_ovf");
    op8(8'h3C, 8'hA5, 1'b1, 1'b0, 5, "t4");

    // reset in the middle of RUN
    @(negedge clk);
    bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b1; bus8.sub = 1'b0; bus8.in_valid = 1'b1;
    @(posedge clk);
    #1 bus8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("t5/out_valid", 32'(bus8.out_valid), 0);
    check_val("t5/in_ready",  32'(bus8.in_ready), 1);
    check_val("t5/sum",       32'(bus8.sum), 0);
    @(negedge clk);
    rst_n = 1'b1;
    op8(8'h01, 8'h01, 1'b0, 1'b0, 0, "t5_after");

    for (int i = 0; i < 1000; i++) op16_random();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
